// File: rtl/dma_wr_data_pkg.sv
// Shared constants and types for the DMA write-data/response engine.
// Default bus widths, the AXI OKAY code and the engine state encoding.
package dma_wr_data_pkg;

  localparam int DEF_AXI_DATA_WIDTH = 32;
  localparam int DEF_DMA_SIZE_WIDTH = 16;
  localparam int DEF_ID_WIDTH       = 4;

  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [7:0] BURST_LEN_FULL = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_WAIT_B = 2'd2
  } wr_state_e;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != AXI_RESP_OKAY;
  endfunction

endpackage

// File: rtl/dma_wr_data_if.sv
// FIFO read stream plus AXI4 W and B channels of the DMA write path.
// master = the write-data engine, slave = FIFO/interconnect side.
interface dma_wr_data_if
  import dma_wr_data_pkg::*;
#(
  parameter int DW  = DEF_AXI_DATA_WIDTH,
  parameter int IDW = DEF_ID_WIDTH
) ();

  logic [DW-1:0]   s_data;
  logic            s_valid;
  logic            s_ready;

  logic [DW-1:0]   M_AXI_WDATA;
  logic [DW/8-1:0] M_AXI_WSTRB;
  logic            M_AXI_WLAST;
  logic            M_AXI_WVALID;
  logic            M_AXI_WREADY;

  logic [IDW-1:0]  M_AXI_BID;
  logic [1:0]      M_AXI_BRESP;
  logic            M_AXI_BVALID;
  logic            M_AXI_BREADY;

  modport master (
    input  s_data, s_valid,
    output s_ready,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
    input  M_AXI_WREADY,
    input  M_AXI_BID, M_AXI_BRESP, M_AXI_BVALID,
    output M_AXI_BREADY
  );

  modport slave (
    output s_data, s_valid,
    input  s_ready,
    input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
    output M_AXI_WREADY,
    output M_AXI_BID, M_AXI_BRESP, M_AXI_BVALID,
    input  M_AXI_BREADY
  );

endinterface

// File: rtl/dma_wr_data_burst_split.sv
// Burst-boundary calculator shared with the write-command stage so both sides
// cut a transfer into identical 256-beat bursts plus a remainder.
module dma_wr_data_burst_split
  import dma_wr_data_pkg::*;
#(
  parameter int SIZE_W = DEF_DMA_SIZE_WIDTH
) (
  input  logic [SIZE_W-1:0] size_i,
  input  logic [SIZE_W-8:0] burst_cnt_i,
  output logic [SIZE_W-8:0] n_bursts_o,
  output logic              last_burst_o,
  output logic [7:0]        burst_len_o
);

  // size[7:0] == 8'hFF lands exactly on a burst edge, so no extra burst appears
  always_comb begin
    n_bursts_o   = {1'b0, size_i[SIZE_W-1:8]} + (SIZE_W-7)'(1);
    last_burst_o = (burst_cnt_i == n_bursts_o - (SIZE_W-7)'(1));
    burst_len_o  = last_burst_o ? size_i[7:0] : BURST_LEN_FULL;
  end

endmodule

// File: rtl/dma_wr_data.sv
// AXI4 write-data (W) and write-response (B) engine of the DMA write path.
// Streams FIFO beats onto W with burst-aligned WLAST and counts one B per burst.
//
// state     | meaning
// ST_IDLE   | waiting for start; all AXI handshake outputs low
// ST_DATA   | passing FIFO beats to W; B responses already accepted
// ST_WAIT_B | W finished; collecting remaining B responses, then done
module dma_wr_data
  import dma_wr_data_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = DEF_AXI_DATA_WIDTH,
  parameter int DMA_SIZE_WIDTH = DEF_DMA_SIZE_WIDTH,
  parameter int ID_WIDTH       = DEF_ID_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [DMA_SIZE_WIDTH-1:0] size,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  dma_wr_data_if.master             bus
);

  localparam int CNT_W = DMA_SIZE_WIDTH - 7;

  wr_state_e                 state_q;
  logic [DMA_SIZE_WIDTH-1:0] size_q;
  logic [7:0]                beat_cnt_q;
  logic [CNT_W-1:0]          burst_cnt_q;
  logic [CNT_W-1:0]          b_cnt_q;
  logic [CNT_W-1:0]          b_cnt_d;
  logic                      err_q;

  logic [CNT_W-1:0]          n_bursts;
  logic                      last_burst;
  logic [7:0]                burst_len;

  logic                      in_xfer;
  logic                      w_on;
  logic                      w_valid;
  logic                      w_fire;
  logic                      w_last_beat;
  logic                      b_fire;
  logic                      b_bad;

  logic [ID_WIDTH-1:0]       unused_bid;
  assign unused_bid = bus.M_AXI_BID;

  dma_wr_data_burst_split #(
    .SIZE_W (DMA_SIZE_WIDTH)
  ) u_split (
    .size_i       (size_q),
    .burst_cnt_i  (burst_cnt_q),
    .n_bursts_o   (n_bursts),
    .last_burst_o (last_burst),
    .burst_len_o  (burst_len)
  );

  // W is a zero-latency pass-through of the FIFO; only the framing is ours
  always_comb begin
    in_xfer          = (state_q != ST_IDLE);
    w_on             = (state_q == ST_DATA);
    w_valid          = w_on & bus.s_valid;
    bus.M_AXI_WVALID = w_valid;
    bus.s_ready      = w_on & bus.M_AXI_WREADY;
    bus.M_AXI_WDATA  = w_on ? bus.s_data : '0;
    bus.M_AXI_WSTRB  = w_on ? '1 : '0;
    w_last_beat      = w_on && (beat_cnt_q == burst_len);
    bus.M_AXI_WLAST  = w_last_beat;
    bus.M_AXI_BREADY = in_xfer;
    w_fire           = w_valid & bus.M_AXI_WREADY;
    b_fire           = in_xfer & bus.M_AXI_BVALID;
    b_bad            = b_fire && resp_is_err(bus.M_AXI_BRESP);
    b_cnt_d          = b_cnt_q + CNT_W'(b_fire);
    // a response accepted this very cycle can complete the transfer
    done             = (state_q == ST_WAIT_B) && (b_cnt_d == n_bursts);
    busy             = in_xfer & ~done;
    err              = err_q | b_bad;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      size_q      <= '0;
      beat_cnt_q  <= '0;
      burst_cnt_q <= '0;
      b_cnt_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            size_q      <= size;
            beat_cnt_q  <= '0;
            burst_cnt_q <= '0;
            b_cnt_q     <= '0;
            err_q       <= 1'b0;
            state_q     <= ST_DATA;
          end
        end
        ST_DATA: begin
          b_cnt_q <= b_cnt_d;
          err_q   <= err;
          if (w_fire) begin
            if (w_last_beat) begin
              beat_cnt_q  <= '0;
              burst_cnt_q <= burst_cnt_q + CNT_W'(1);
              if (last_burst) begin
                state_q <= ST_WAIT_B;
              end
            end else begin
              beat_cnt_q <= beat_cnt_q + 8'd1;
            end
          end
        end
        ST_WAIT_B: begin
          b_cnt_q <= b_cnt_d;
          err_q   <= err;
          if (done) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_wr_data.sv
// Randomized bench for dma_wr_data against a transfer-level reference model:
// beat queue, WLAST every 256th beat or at the end, one B per burst.
module tb_dma_wr_data;

  localparam int DW   = 32;
  localparam int SW   = 16;
  localparam int IDW  = 4;
  localparam int HALF = 5;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [SW-1:0] size  = '0;
  logic          busy;
  logic          done;
  logic          err;

  dma_wr_data_if #(.DW(DW), .IDW(IDW)) bus ();

  dma_wr_data #(
    .AXI_DATA_WIDTH (DW),
    .DMA_SIZE_WIDTH (SW),
    .ID_WIDTH       (IDW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .size  (size),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .bus   (bus)
  );

  always #HALF clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] fifo_q[$];
  logic [1:0]    bresp_plan[$];
  int            total, beats_sent, n_exp, b_acc, b_pend, xfer_cyc;
  bit            active, w_complete, fin, err_exp;
  int            src_stall, wr_stall, b_stall, src_delay;
  bit            b_early;
  bit            start_req;
  logic [SW-1:0] size_drv;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: drive at negedge, sample just before the next posedge.
  task automatic cycle();
    bit         s_v, w_r, b_v, whs, bhs, exp_last, exp_done, err_now;
    logic [1:0] br;
    @(negedge clk);
    start     = start_req;
    size      = size_drv;
    start_req = 1'b0;
    if (active)
      s_v = !w_complete && (fifo_q.size() > 0) && (xfer_cyc >= src_delay) &&
            ($urandom_range(99) >= src_stall);
    else
      s_v = ($urandom_range(1) == 1);
    w_r = ($urandom_range(99) >= wr_stall);
    b_v = active && (b_early ? (b_acc < n_exp) : (b_pend > 0)) &&
          ($urandom_range(99) >= b_stall);
    br  = b_v ? bresp_plan[b_acc] : 2'b00;
    bus.s_valid      = s_v;
    bus.s_data       = (active && s_v) ? fifo_q[0] : DW'($urandom);
    bus.M_AXI_WREADY = w_r;
    bus.M_AXI_BVALID = b_v;
    bus.M_AXI_BRESP  = br;
    bus.M_AXI_BID    = IDW'($urandom);
    #(HALF - 1);
    if (active) begin
      whs = s_v && w_r;
      bhs = b_v;
      chk("wvalid", bus.M_AXI_WVALID, s_v);
      chk("s_ready", bus.s_ready, w_r && !w_complete);
      if (whs) begin
        exp_last = (((beats_sent + 1) % 256) == 0) || (beats_sent + 1 == total);
        chk("wdata", bus.M_AXI_WDATA, fifo_q[0]);
        chk("wlast", bus.M_AXI_WLAST, exp_last);
        chk("wstrb", bus.M_AXI_WSTRB, {(DW/8){1'b1}});
      end else begin
        exp_last = 1'b0;
      end
      if (bhs) chk("bready", bus.M_AXI_BREADY, 1'b1);
      err_now  = err_exp | (bhs && (br != 2'b00));
      exp_done = w_complete && (b_acc + int'(bhs) == n_exp);
      chk("done", done, exp_done);
      chk("busy", busy, !exp_done);
      chk("err", err, err_now);
      if (whs) begin
        void'(fifo_q.pop_front());
        beats_sent++;
        if (exp_last) b_pend++;
        if (beats_sent == total) w_complete = 1'b1;
      end
      if (bhs) begin
        b_acc++;
        if (b_pend > 0) b_pend--;
      end
      err_exp = err_now;
      if (exp_done) begin
        active = 1'b0;
        fin    = 1'b1;
      end
      xfer_cyc++;
    end else begin
      chk("idle_wvalid", bus.M_AXI_WVALID, 1'b0);
      chk("idle_wlast", bus.M_AXI_WLAST, 1'b0);
      chk("idle_s_ready", bus.s_ready, 1'b0);
      chk("idle_bready", bus.M_AXI_BREADY, 1'b0);
      chk("idle_done", done, 1'b0);
      chk("idle_busy", busy, 1'b0);
      chk("err_hold", err, err_exp);
    end
  endtask

  task automatic start_xfer(input int sz, input int bad_idx);
    start_req = 1'b1;
    size_drv  = SW'(sz);
    cycle();
    total = sz + 1;
    n_exp = (total + 255) / 256;
    fifo_q.delete();
    for (int i = 0; i < total; i++) fifo_q.push_back(DW'($urandom));
    bresp_plan.delete();
    for (int i = 0; i < n_exp; i++)
      bresp_plan.push_back((i == bad_idx) ? 2'($urandom_range(3, 1)) : 2'b00);
    beats_sent = 0;
    b_acc      = 0;
    b_pend     = 0;
    xfer_cyc   = 0;
    w_complete = 1'b0;
    fin        = 1'b0;
    err_exp    = 1'b0;
    active     = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_wvalid", bus.M_AXI_WVALID, 1'b0);
    chk("rst_wlast", bus.M_AXI_WLAST, 1'b0);
    chk("rst_s_ready", bus.s_ready, 1'b0);
    chk("rst_bready", bus.M_AXI_BREADY, 1'b0);
    chk("rst_wdata", bus.M_AXI_WDATA, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    active     = 1'b0;
    w_complete = 1'b0;
    fin        = 1'b0;
    err_exp    = 1'b0;
    fifo_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_to_done(input int budget);
    int c = 0;
    while (!fin && c < budget) begin
      cycle();
      c++;
    end
    if (!fin) begin
      chk("timeout_done", 1'b0, 1'b1);
      do_reset();
    end
  endtask

  initial begin
    bus.s_valid      = 1'b0;
    bus.s_data       = '0;
    bus.M_AXI_WREADY = 1'b0;
    bus.M_AXI_BVALID = 1'b0;
    bus.M_AXI_BRESP  = 2'b00;
    bus.M_AXI_BID    = '0;
    start_req = 1'b0;
    size_drv  = '0;
    active    = 1'b0;
    err_exp   = 1'b0;
    src_stall = 0; wr_stall = 0; b_stall = 0; src_delay = 0; b_early = 1'b0;

    #2;
    chk("por_busy", busy, 1'b0);
    chk("por_done", done, 1'b0);
    chk("por_err", err, 1'b0);
    chk("por_wvalid", bus.M_AXI_WVALID, 1'b0);
    chk("por_bready", bus.M_AXI_BREADY, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) cycle();

    // single beat
    start_xfer(0, -1);   run_to_done(100);
    // two full bursts, continuous
    start_xfer(511, -1); run_to_done(2000);
    // remainder burst under random stalls
    src_stall = 30; wr_stall = 30; b_stall = 50;
    start_xfer(300, -1); run_to_done(4000);
    // exact single full burst
    src_stall = 0; wr_stall = 0; b_stall = 0;
    start_xfer(255, -1); run_to_done(2000);
    // all responses before the W phase ends: done on WAIT_B entry
    b_early = 1'b1; src_delay = 4;
    start_xfer(0, -1);   run_to_done(100);
    start_xfer(511, -1); run_to_done(2000);
    b_early = 1'b0; src_delay = 0;
    // error on second response, held through idle, cleared on next start
    start_xfer(511, 1);  run_to_done(2000);
    repeat (5) cycle();
    start_xfer(2, -1);   run_to_done(100);
    // start while busy is ignored; then reset mid-burst
    src_stall = 20;
    start_xfer(40, -1);
    repeat (5) cycle();
    start_req = 1'b1; size_drv = SW'(5);
    begin
      int c = 0;
      while (beats_sent < 30 && c < 400) begin
        cycle();
        c++;
      end
      if (beats_sent < 30) chk("timeout_beats", 1'b0, 1'b1);
    end
    do_reset();
    src_stall = 0;
    start_xfer(3, -1);   run_to_done(200);
    // randomized transfers
    for (int i = 0; i < 6; i++) begin
      int sz;
      sz        = $urandom_range(700);
      src_stall = $urandom_range(40);
      wr_stall  = $urandom_range(40);
      b_stall   = $urandom_range(60);
      start_xfer(sz, int'($urandom_range(3)) - 1);
      run_to_done(8000);
      repeat ($urandom_range(3)) cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
